spi_target: RTL and testbench

- SPI mode-0 target (responder) on the external host port; the mirror of the on-chip flash-reading SPI initiator.
- Lets an external host write the display register file over the same load/addr/data write strobe the initiator drives, and read back register contents.
- Fully synchronous to the system clock. The SPI pins are oversampled; no logic runs on the sclk edges.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync.sv | 53 +++++
 rtl/spi_target.sv | 164 ++++++++++++++++
 tb/tb_spi_target.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: target FSM state encoding and the command opcodes
// understood by both the on-chip initiator and the external-host target.
// Latency: n/a (types and constants only). Backpressure: n/a.
package spi_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;  // burst write: cmd, addr, data...
  localparam logic [7:0] OP_READ  = 8'h03;  // burst read:  cmd, addr, then clock out

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } spi_target_state_t;

endpackage

// File: rtl/spi_sync.sv
// Oversampling synchronizer for the SPI pins with sclk edge and cs fall detect.
// Latency: STAGES clks pin-to-sync; edge strobes are combinational off the sync outputs.
// Backpressure: none; free-running sampler.
//
// Ports: clk/rst system clock and sync reset; sclk/cs/mosi raw pins;
// sclk_rise/sclk_fall one-cycle edge strobes; cs_sync/mosi_sync synchronized
// levels; cs_fall one-cycle strobe on chip-select assertion.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_sync,
  output logic cs_fall,
  output logic mosi_sync
);

  logic [STAGES-1:0] sclk_q;
  logic [STAGES-1:0] cs_q;
  logic [STAGES-1:0] mosi_q;
  logic              sclk_prev;
  logic              cs_prev;

  // All chains reset to 0: a chip select already low at reset release is
  // then never mistaken for a fresh assertion.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= '0;
      cs_q      <= '0;
      mosi_q    <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[STAGES-2:0], sclk};
      cs_q      <= {cs_q[STAGES-2:0], cs};
      mosi_q    <= {mosi_q[STAGES-2:0], mosi};
      sclk_prev <= sclk_q[STAGES-1];
      cs_prev   <= cs_q[STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_q[STAGES-1] & sclk_prev;
  assign cs_sync   = cs_q[STAGES-1];
  assign cs_fall   = ~cs_q[STAGES-1] & cs_prev;
  assign mosi_sync = mosi_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target giving an external host burst write/read of the register file.
// Latency: load SYNC_STAGES+2 clks after 8th data sclk rise; MISO bit SYNC_STAGES+1 after sclk fall.
// Backpressure: none; host pacing bounded by f_clk >= 8*f_sclk, rd_data must return 1 clk after rd_en.
//
// Ports: clk/rst system clock, sync active-high reset; s_sclk/s_cs/s_mosi host
// pins in; s_miso/s_miso_oe host data out and its enable; load/addr/data
// register write strobe; rd_en/rd_addr/rd_data register read port; busy while
// a transaction is open.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] OP_WRITE    = spi_pkg::OP_WRITE,
  parameter logic [7:0] OP_READ     = spi_pkg::OP_READ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_sclk,
  input  logic       s_cs,
  input  logic       s_mosi,
  output logic       s_miso,
  output logic       s_miso_oe,
  output logic       load,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  import spi_pkg::*;

  logic sclk_rise, sclk_fall, cs_sync, cs_fall, mosi_sync;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (s_sclk),
    .cs        (s_cs),
    .mosi      (s_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_sync   (cs_sync),
    .cs_fall   (cs_fall),
    .mosi_sync (mosi_sync)
  );

  spi_target_state_t state, state_nxt;

  logic [2:0] bit_cnt;
  logic [7:0] shreg;      // incoming byte, MSB first
  logic [7:0] byte_val;   // shreg with the current bit folded in
  logic       byte_done;  // this rise is the 8th of a byte
  logic       is_read;
  logic [7:0] ptr;
  logic       wr_pend;    // data byte complete, strobe load next clk
  logic       pf_pend;    // rd_data is valid this cycle
  logic [7:0] prefetch;
  logic [6:0] miso_sh;    // bits still to be shifted out after the MSB

  assign byte_val  = {shreg[6:0], mosi_sync};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  always_comb begin
    state_nxt = state;
    if (cs_sync) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (byte_val == OP_WRITE || byte_val == OP_READ) state_nxt = ST_ADDR;
            else                                              state_nxt = ST_IGNORE;
          end
        end
        ST_ADDR: if (byte_done) state_nxt = is_read ? ST_RDATA : ST_WDATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      is_read  <= 1'b0;
      ptr      <= 8'd0;
      wr_pend  <= 1'b0;
      pf_pend  <= 1'b0;
      prefetch <= 8'd0;
      miso_sh  <= 7'd0;
      s_miso   <= 1'b0;
      load     <= 1'b0;
      addr     <= 8'd0;
      data     <= 8'd0;
      rd_en    <= 1'b0;
      rd_addr  <= 8'd0;
    end else begin
      state   <= state_nxt;
      load    <= 1'b0;
      rd_en   <= 1'b0;
      wr_pend <= 1'b0;
      pf_pend <= rd_en;

      if (pf_pend) prefetch <= rd_data;

      // Bit counter wraps 7->0 on the 8th rise; cs high discards a partial byte.
      if (cs_sync || state == ST_IDLE) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shreg   <= byte_val;
        bit_cnt <= bit_cnt + 3'd1;
      end

      // shreg still holds the completed data byte here: the next rise is
      // at least 8 clks away.
      if (wr_pend) begin
        load <= 1'b1;
        addr <= ptr;
        data <= shreg;
        ptr  <= ptr + 8'd1;
      end

      if (!cs_sync && byte_done) begin
        case (state)
          ST_CMD:   is_read <= (byte_val == OP_READ);
          ST_ADDR: begin
            ptr <= byte_val;
            if (is_read) begin
              rd_en   <= 1'b1;
              rd_addr <= byte_val;
            end
          end
          ST_WDATA: wr_pend <= 1'b1;
          default:  ;
        endcase
      end

      // Byte boundary on the falling edge: hand the prefetched byte to the
      // shifter and immediately request the next address.
      if (state == ST_RDATA && !cs_sync) begin
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) begin
            s_miso  <= prefetch[7];
            miso_sh <= prefetch[6:0];
            rd_en   <= 1'b1;
            rd_addr <= ptr + 8'd1;
            ptr     <= ptr + 8'd1;
          end else begin
            s_miso  <= miso_sh[6];
            miso_sh <= {miso_sh[5:0], 1'b0};
          end
        end
      end else if (state != ST_RDATA) begin
        s_miso <= 1'b0;
      end
    end
  end

  assign s_miso_oe = (state == ST_RDATA) && !cs_sync;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_sclk = 1'b0;
  logic       s_cs = 1'b1;
  logic       s_mosi = 1'b0;
  logic       s_miso, s_miso_oe, load, rd_en, busy;
  logic [7:0] addr, data, rd_addr;
  logic [7:0] rd_data = 8'd0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: mem[i] = i ^ 0x5A, data returned one clk after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= rd_addr ^ 8'h5A;

  spi_target #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_sclk    (s_sclk),
    .s_cs      (s_cs),
    .s_mosi    (s_mosi),
    .s_miso    (s_miso),
    .s_miso_oe (s_miso_oe),
    .load      (load),
    .addr      (addr),
    .data      (data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  logic [15:0] exp_load_q[$];
  logic [15:0] got_load_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  got_rd_q[$];
  logic [7:0]  tx[16];
  logic [7:0]  rx[16];
  logic [7:0]  last_addr = 8'd0;
  logic [7:0]  last_data = 8'd0;
  bit          rd_window = 1'b0;
  int          half = 4;
  int          last_rise_cyc = 0;
  int          last_load_cyc = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] got);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected none (cycle %0d)", name, got, cyc);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the expectation queues built from the bytes sent.
  initial begin
    logic        r;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        chk("rst_load", load, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_miso", s_miso, 0);
        chk("rst_miso_oe", s_miso_oe, 0);
        chk("rst_busy", busy, 0);
        last_addr = 8'd0;
        last_data = 8'd0;
      end else begin
        if (load) begin
          got_load_q.push_back({addr, data});
          last_load_cyc = cyc;
          if (exp_load_q.size() == 0) begin
            unexpected("unexp_load", {addr, data});
          end else begin
            e = exp_load_q.pop_front();
            chk("load_addr", addr, e[15:8]);
            chk("load_data", data, e[7:0]);
            last_addr = e[15:8];
            last_data = e[7:0];
          end
        end else begin
          chk("addr_hold", addr, last_addr);
          chk("data_hold", data, last_data);
        end
        if (rd_en) begin
          got_rd_q.push_back(rd_addr);
          if (exp_rd_q.size() == 0) unexpected("unexp_rd_en", rd_addr);
          else chk("rd_addr", rd_addr, exp_rd_q.pop_front());
        end
        if (!rd_window) chk("oe_idle", s_miso_oe, 0);
      end
    end
  end

  // Host: sends tx[] (nbytes full bytes plus extra bits), mode 0, MSB first.
  task automatic xfer(input int nbytes, input int extra, input bit keep_cs);
    int         total;
    int         nrd;
    logic [7:0] op;
    logic [7:0] ptr;
    logic [7:0] rxb;
    op    = tx[0];
    ptr   = tx[1];
    total = nbytes * 8 + extra;
    got_load_q.delete();
    got_rd_q.delete();

    if (nbytes >= 2 && op == 8'h02) begin
      for (int j = 2; j < nbytes; j++) begin
        exp_load_q.push_back({ptr, tx[j]});
        ptr = ptr + 8'd1;
      end
    end
    if (nbytes >= 2 && op == 8'h03) begin
      nrd = nbytes - 1 + ((extra > 0) ? 1 : 0);
      for (int j = 0; j < nrd; j++) exp_rd_q.push_back(8'(tx[1] + j));
      rd_window = 1'b1;
    end

    s_cs = 1'b0;
    tick(half);
    chk("busy_start", busy, 1);
    rxb = 8'd0;
    for (int i = 0; i < total; i++) begin
      if (i > 0) s_sclk = 1'b0;
      s_mosi = tx[i / 8][7 - (i % 8)];
      tick(half);
      if (op == 8'h03 && nbytes >= 2 && i >= 16) begin
        chk("miso_oe", s_miso_oe, 1);
        rxb = {rxb[6:0], s_miso};
        if (i % 8 == 7) begin
          rx[i / 8 - 2] = rxb;
          chk("miso_byte", rxb, (8'(tx[1] + (i / 8 - 2))) ^ 8'h5A);
        end
      end
      s_sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(half);
    end

    if (!keep_cs) begin
      s_cs = 1'b1;
      tick(2);
      s_sclk = 1'b0;
      tick(2 * half);
      chk("busy_end", busy, 0);
      rd_window = 1'b0;
      chk("load_left", exp_load_q.size(), 0);
      chk("rd_left", exp_rd_q.size(), 0);
    end
  endtask

  initial begin
    int nb;
    int ex;
    int sel;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single write, f_sclk = f_clk/8
    half = 4;
    tx[0] = 8'h02; tx[1] = 8'h05; tx[2] = 8'hA5;
    xfer(3, 0, 1'b0);
    chk("t1_nload", got_load_q.size(), 1);
    chk("t1_load", (got_load_q.size() > 0) ? got_load_q[0] : 16'h0, 16'h05A5);
    chk("t1_latency", last_load_cyc - last_rise_cyc, SYNC + 2);

    // Burst write with pointer wrap
    tx[0] = 8'h02; tx[1] = 8'hFE; tx[2] = 8'h11; tx[3] = 8'h22; tx[4] = 8'h33;
    xfer(5, 0, 1'b0);
    chk("t2_nload", got_load_q.size(), 3);
    chk("t2_load2", (got_load_q.size() > 2) ? got_load_q[2] : 16'hFFFF, 16'h0033);
    chk("t2_load1", (got_load_q.size() > 1) ? got_load_q[1] : 16'h0, 16'hFF22);

    // Burst read of two bytes from 0x07
    tx[0] = 8'h03; tx[1] = 8'h07; tx[2] = 8'h00; tx[3] = 8'h00;
    xfer(4, 0, 1'b0);
    chk("t3_rx0", rx[0], 8'h5D);
    chk("t3_rx1", rx[1], 8'h52);
    chk("t3_nrd", got_rd_q.size(), 3);
    chk("t3_rd2", (got_rd_q.size() > 2) ? got_rd_q[2] : 8'h0, 8'h09);

    // Unknown opcode is ignored
    tx[0] = 8'h9F; tx[1] = 8'h00; tx[2] = 8'h00;
    xfer(3, 0, 1'b0);
    chk("t4_nload", got_load_q.size(), 0);
    chk("t4_nrd", got_rd_q.size(), 0);

    // Partial data byte discarded, then a complete write
    tx[0] = 8'h02; tx[1] = 8'h10; tx[2] = 8'hFF;
    xfer(2, 5, 1'b0);
    chk("t5a_nload", got_load_q.size(), 0);
    tx[2] = 8'hC3;
    xfer(3, 0, 1'b0);
    chk("t5_load", (got_load_q.size() > 0) ? got_load_q[0] : 16'h0, 16'h10C3);
    chk("t5_nload", got_load_q.size(), 1);

    // Reset mid data byte, then a normal write
    tx[0] = 8'h02; tx[1] = 8'h01; tx[2] = 8'hFF;
    xfer(2, 3, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    s_cs = 1'b1;
    s_sclk = 1'b0;
    tick(6);
    chk("t6_busy", busy, 0);
    tx[2] = 8'h7E;
    xfer(3, 0, 1'b0);
    chk("t6_load", (got_load_q.size() > 0) ? got_load_q[0] : 16'h0, 16'h017E);

    // Randomized transactions against the queue model
    repeat (30) begin
      sel = $urandom_range(0, 2);
      for (int j = 0; j < 16; j++) tx[j] = 8'($urandom);
      if (sel == 0) tx[0] = 8'h02;
      else if (sel == 1) tx[0] = 8'h03;
      else while (tx[0] == 8'h02 || tx[0] == 8'h03) tx[0] = 8'($urandom);
      nb   = $urandom_range(1, 5);
      ex   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      half = $urandom_range(4, 6);
      xfer(nb, ex, 1'b0);
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
